// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state enum, one-hot and clog2 helpers for decoder_nto2n_seq
package dec_pkg;

  localparam int DEC_MAX_SEL_W = 8;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_PULSE,
    ST_SCAN
  } dec_state_e;

  // Callers size-cast the result down to their own OUT_W.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot(input int idx);
    return DEC_MAX_OUT_W'(1) << idx;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_prescaler.sv
// rtl/dec_prescaler.sv - scan step prescaler: one-cycle tick every DIV cycles while active
module dec_prescaler
  import dec_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = active && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!active || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// rtl/decoder_nto2n_seq.sv - registered N-to-2^N one-hot decoder (hold/pulse; scan when DEC_SCAN_EN)
module decoder_nto2n_seq
  import dec_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int PULSE     = 0,
  parameter int PULSE_LEN = 4,
  parameter int SCAN_DIV  = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  input  logic                   scan,
  output logic [(1<<SEL_W)-1:0]  dout,
  output logic                   dout_valid
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int PC_W  = clog2(PULSE_LEN);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_LEN - 1);

  dec_state_e       state_q, state_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
  logic [OUT_W-1:0] dout_d;
  logic             scan_eff, scan_tick, accept;

`ifdef DEC_SCAN_EN
  logic scan_active;

  assign scan_eff    = scan;
  assign scan_active = (state_q == ST_SCAN);

  dec_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (scan_active),
    .tick    (scan_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan_idx_q <= '0;
    else          scan_idx_q <= scan_idx_d;
  end
`else
  localparam int unused_scan_div = SCAN_DIV;
  logic scan_unused;

  assign scan_eff    = 1'b0;
  assign scan_tick   = 1'b0;
  assign scan_idx_q  = '0;
  assign scan_unused = ^{scan, scan_idx_d};
`endif

  // Reset gates ready combinationally so nothing is accepted while reset_n is low.
  assign sel_ready = reset_n & en & ~clear & ~scan_eff &
                     ((state_q == ST_IDLE) | (state_q == ST_HOLD));
  assign accept    = sel_valid & sel_ready;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    scan_idx_d = scan_idx_q;
    dout_d     = dout;
    if (!en || clear) begin
      state_d    = ST_IDLE;
      pcnt_d     = '0;
      scan_idx_d = '0;
      dout_d     = '0;
    end else if (scan_eff) begin
      state_d = ST_SCAN;
      pcnt_d  = '0;
      if (state_q != ST_SCAN) scan_idx_d = '0;
      else if (scan_tick)     scan_idx_d = scan_idx_q + 1'b1;
      dout_d = OUT_W'(onehot(int'(scan_idx_d)));
    end else if (state_q == ST_SCAN) begin
      state_d    = ST_IDLE;
      scan_idx_d = '0;
      dout_d     = '0;
    end else if (state_q == ST_PULSE) begin
      if (pcnt_q == PC_LAST) begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
        dout_d  = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end else if (accept) begin
      state_d = (PULSE != 0) ? ST_PULSE : ST_HOLD;
      pcnt_d  = '0;
      dout_d  = OUT_W'(onehot(int'(sel)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      dout       <= dout_d;
      dout_valid <= |dout_d;
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// tb/tb_decoder_nto2n_seq.sv - self-checking bench for decoder_nto2n_seq (hold, pulse, 1-bit strobe)
module tb_decoder_nto2n_seq;

  logic       clk = 1'b0;
  logic       reset_n, en, clear, sel_valid, scan;
  logic [1:0] sel;
  logic [3:0] dout0, dout1;
  logic [1:0] dout2;
  logic       dv0, dv1, dv2, rdy0, rdy1, rdy2;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DEC_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif
  localparam int SDIV = 2;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.SEL_W(2), .PULSE(0), .PULSE_LEN(4), .SCAN_DIV(SDIV)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy0), .scan(scan), .dout(dout0), .dout_valid(dv0));

  decoder_nto2n_seq #(.SEL_W(2), .PULSE(1), .PULSE_LEN(3), .SCAN_DIV(SDIV)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(rdy1), .scan(scan), .dout(dout1), .dout_valid(dv1));

  decoder_nto2n_seq #(.SEL_W(1), .PULSE(1), .PULSE_LEN(1), .SCAN_DIV(SDIV)) u2 (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .sel(sel[0:0]), .sel_valid(sel_valid),
    .sel_ready(rdy2), .scan(scan), .dout(dout2), .dout_valid(dv2));

  logic [3:0] dout_a [3];
  logic       dv_a   [3];
  logic       rdy_a  [3];
  assign dout_a[0] = dout0;
  assign dout_a[1] = dout1;
  assign dout_a[2] = {2'b00, dout2};
  assign dv_a[0] = dv0;
  assign dv_a[1] = dv1;
  assign dv_a[2] = dv2;
  assign rdy_a[0] = rdy0;
  assign rdy_a[1] = rdy1;
  assign rdy_a[2] = rdy2;

  // Model: which line is lit (-1 none), pulse cycles still to show, scan position/age.
  int m_line [3];
  int m_left [3];
  int m_pos  [3];
  int m_age  [3];
  bit m_scanning [3];

  function automatic int outw(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic int plen(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic logic [3:0] exp_dout(input int k);
    return (m_line[k] < 0) ? 4'b0000 : 4'(1 << m_line[k]);
  endfunction

  function automatic logic m_ready(input int k);
    return reset_n && en && !clear && !(SCAN_ON && scan) && (m_left[k] == 0) && !m_scanning[k];
  endfunction

  task automatic model_step(input int k);
    logic rdy;
    rdy = m_ready(k);
    if (!en || clear) begin
      m_line[k] = -1; m_left[k] = 0; m_scanning[k] = 1'b0;
    end else if (SCAN_ON && scan) begin
      if (!m_scanning[k]) begin
        m_scanning[k] = 1'b1; m_pos[k] = 0; m_age[k] = 0;
      end else begin
        m_age[k]++;
        if (m_age[k] == SDIV) begin
          m_age[k] = 0;
          m_pos[k] = (m_pos[k] + 1) % outw(k);
        end
      end
      m_line[k] = m_pos[k];
      m_left[k] = 0;
    end else if (m_scanning[k]) begin
      m_scanning[k] = 1'b0; m_line[k] = -1;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) m_line[k] = -1;
    end else if (sel_valid && rdy) begin
      m_line[k] = int'(sel) % outw(k);
      m_left[k] = plen(k);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        m_line[k] = -1; m_left[k] = 0; m_pos[k] = 0; m_age[k] = 0; m_scanning[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cyc_dout%0d", k), dout_a[k], exp_dout(k));
      check($sformatf("cyc_dvalid%0d", k), 4'(dv_a[k]), 4'(exp_dout(k) != 4'b0000));
      check($sformatf("cyc_ready%0d", k), 4'(rdy_a[k]), 4'(m_ready(k)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef DEC_SCAN_EN
  logic [3:0] scan_seq [9];
`endif

  initial begin
    reset_n = 1'b0; en = 1'b0; clear = 1'b0; sel = 2'd0; sel_valid = 1'b0; scan = 1'b0;
    repeat (2) tick();
    check("reset_dout", dout0, 4'b0000);
    check("reset_ready", 4'(rdy0), 4'b0000);
    reset_n = 1'b1; en = 1'b1;
    #1 check("release_ready", 4'(rdy0), 4'b0001);

    // hold: sel=2 held for 10 cycles, then sel=3
    sel = 2'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    check("t1_hold", dout0, 4'b0100);
    check("t1_pulse", dout1, 4'b0100);
    check("t1_sel1", {2'b00, dout2}, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_held", dout0, 4'b0100);
    end
    sel = 2'd3; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    check("t1_replace", dout0, 4'b1000);
    check("t1_strobe", {2'b00, dout2}, 4'b0010);

    // pulse of 3 cycles, then back-to-back accept
    repeat (4) tick();
    sel = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    check("t2_strobe_on", {2'b00, dout2}, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      check("t2_pulse_on", dout1, 4'b0010);
      check("t2_ready_low", 4'(rdy1), 4'b0000);
      tick();
    end
    check("t2_pulse_off", dout1, 4'b0000);
    check("t2_strobe_off", {2'b00, dout2}, 4'b0000);
    sel = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    check("t2_b2b", dout1, 4'b0001);
    check("t2_hold0", dout0, 4'b0001);

    // clear beats a simultaneous select
    clear = 1'b1; sel = 2'd2; sel_valid = 1'b1;
    #1 check("t3_ready_low", 4'(rdy0), 4'b0000);
    tick();
    clear = 1'b0; sel_valid = 1'b0; sel = 'x;
    check("t3_cleared", dout0, 4'b0000);
    check("t3_dvalid", 4'(dv0), 4'b0000);
    tick();
    check("t3_idle", dout0, 4'b0000);

    // async reset in the middle of a pulse
    sel = 2'd3; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    tick();
    check("t4_mid", dout1, 4'b1000);
    #2 reset_n = 1'b0;
    #1 check("t4_async", dout1, 4'b0000);
    check("t4_async_dv", 4'(dv1), 4'b0000);
    tick();
    reset_n = 1'b1;
    #1 check("t4_ready", 4'(rdy1), 4'b0001);
    tick();
    check("t4_idle", dout1, 4'b0000);

    // enable low during hold
    sel = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    check("t6_hold", dout0, 4'b0010);
    en = 1'b0;
    #1 check("t6_ready_low", 4'(rdy0), 4'b0000);
    tick();
    check("t6_off", dout0, 4'b0000);
    tick();
    en = 1'b1;
    tick();
    check("t6_still_off", dout0, 4'b0000);
    sel = 2'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; sel = 'x;
    check("t6_decode", dout0, 4'b0100);

`ifdef DEC_SCAN_EN
    scan_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    scan = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("t5_scan%0d", i), dout0, scan_seq[i]);
    end
    scan = 1'b0;
    tick();
    check("t5_scan_off", dout0, 4'b0000);
`else
    scan = 1'b1;
    repeat (3) tick();
    check("t5_scan_ignored", dout0, 4'b0100);
    check("t5_ready", 4'(rdy0), 4'b0001);
    scan = 1'b0;
`endif
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
